// File: rtl/div_if.sv
// Divider handshake bundle between the execute stage (master) and div_unit (slave).
interface div_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               signed_div;
    logic               cancel;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               div_stall;
    logic               ready;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, signed_div, cancel, a, b,
        input  div_stall, ready, result
    );

    modport slave (
        input  start, signed_div, cancel, a, b,
        output div_stall, ready, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU producing {HI=remainder, LO=quotient}.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  resetn,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] result;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               accept;
    logic               b_zero;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               fits;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign abs_a  = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b  = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign accept = (state == IDLE) && bus.start && !bus.cancel;
    assign b_zero = (bus.b == '0);

    // The shifted partial remainder needs one extra bit: it can exceed 2^WIDTH-1
    // when the divisor magnitude is above 2^(WIDTH-1).
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor};
    assign fits      = (rem_shift >= {1'b0, divisor});
    assign rem_step  = fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_step  = {quo[WIDTH-2:0], fits};
    assign q_fix     = neg_q ? -quo_step : quo_step;
    assign r_fix     = neg_r ? -rem_step : rem_step;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (b_zero) begin
                        state_next = DONE;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (abs_a < abs_b) begin
                        state_next = DONE;
                    end
`endif
                    else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.cancel) begin
                    state_next = IDLE;
                end else if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
        end else begin
            if (accept) begin
                count   <= CW'(WIDTH);
                rem     <= '0;
                quo     <= abs_a;
                divisor <= abs_b;
                neg_q   <= bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r   <= bus.signed_div && bus.a[WIDTH-1];
                // Short-circuit results bypass sign fix-up and return the raw dividend in HI.
                if (b_zero) begin
                    result <= {bus.a, {WIDTH{1'b1}}};
                end
`ifdef DIV_EARLY_OUT_EN
                else if (abs_a < abs_b) begin
                    result <= {bus.a, {WIDTH{1'b0}}};
                end
`endif
            end else if (state == BUSY && !bus.cancel) begin
                rem   <= rem_step;
                quo   <= quo_step;
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    result <= {r_fix, q_fix};
                end
            end
        end
    end

    assign bus.div_stall = accept || (state == BUSY);
    assign bus.ready     = (state == DONE) && !bus.cancel;
    assign bus.result    = result;
endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;
    localparam int W = 32;

    logic clk;
    logic resetn;
    int   total;
    int   bad;
    logic [63:0] prev_result;

    div_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic longint magnitude(input logic [31:0] x, input logic sgn);
        longint v;
        v = sgn ? longint'($signed(x)) : longint'({32'd0, x});
        return (v < 0) ? -v : v;
    endfunction

    function automatic int expLatency(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (magnitude(a, sgn) < magnitude(b, sgn)) return 1;
`endif
        return W + 1;
    endfunction

    // Entered and left at #1 after a rising edge; start is held until the edge after DONE.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        int stalls;
        int cyc;
        logic [63:0] exp_res;
        exp_res = model(a, b, sgn);
        bus.a = a;
        bus.b = b;
        bus.signed_div = sgn;
        bus.start = 1'b1;
        #1;
        stalls = bus.div_stall ? 1 : 0;
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                cyc = i;
                break;
            end
            if (bus.div_stall) stalls++;
        end
        if (cyc == 0) begin
            checkOutput("timeout", 64'd1, 64'd0);
        end else begin
            checkOutput("result", bus.result, exp_res);
            checkOutput("latency", 64'(cyc), 64'(expLatency(a, b, sgn)));
            checkOutput("stalls", 64'(stalls), 64'(expLatency(a, b, sgn)));
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        #1;
        checkOutput("ready_pulse", {63'd0, bus.ready}, 64'd0);
        checkOutput("idle_stall", {63'd0, bus.div_stall}, 64'd0);
        checkOutput("result_hold", bus.result, exp_res);
        prev_result = exp_res;
        @(posedge clk);
        #1;
    endtask

    task automatic expectNoReady(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready) seen++;
        end
        checkOutput(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        total = 0;
        bad = 0;
        prev_result = '0;
        resetn = 1'b0;
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        bus.signed_div = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {63'd0, bus.ready}, 64'd0);
        checkOutput("reset_stall", {63'd0, bus.div_stall}, 64'd0);
        checkOutput("reset_result", bus.result, 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(32'd100, 32'd7, 1'b0);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(32'd5, 32'd0, 1'b0);
        applyStimulus(32'd3, 32'd9, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1);

        // Cancel while BUSY with ten iterations left.
        bus.a = 32'd1000;
        bus.b = 32'd3;
        bus.signed_div = 1'b0;
        bus.start = 1'b1;
        repeat (23) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        bus.start = 1'b0;
        #1;
        checkOutput("cancel_busy_stall", {63'd0, bus.div_stall}, 64'd1);
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        #1;
        checkOutput("cancel_stall", {63'd0, bus.div_stall}, 64'd0);
        checkOutput("cancel_result", bus.result, prev_result);
        expectNoReady(40, "cancel_no_ready");

        // Cancel beats start in IDLE.
        bus.start = 1'b1;
        bus.cancel = 1'b1;
        #1;
        checkOutput("cancel_idle_stall", {63'd0, bus.div_stall}, 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        expectNoReady(40, "cancel_idle_no_ready");

        // Reset mid-operation drops the op.
        bus.a = 32'd12345;
        bus.b = 32'd11;
        bus.start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        checkOutput("midreset_result", bus.result, 64'd0);
        checkOutput("midreset_stall", {63'd0, bus.div_stall}, 64'd0);
        expectNoReady(40, "midreset_no_ready");

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 20);
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = -$urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
